// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch path and the branch-target LUT.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned CYC_W = 16;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: start/halt FSM, next-PC mux and
// saturating RUN-cycle counter for the Done handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned W  = PC_W,
  parameter int unsigned CW = CYC_W
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [W-1:0]  Start_Addr,
  input  logic          Stall,
  input  logic          Branch_En,
  input  logic          Branch_Rel,
  input  logic [W-1:0]  Target,
  input  logic          Halt_req,
  output logic [W-1:0]  PC,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] Cycle_Count
);

  fetch_state_t state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic         running_q;
  logic         done_q;
  logic         cnt_clr;
  logic         cnt_en;

  // Stall outranks halt and branch; a halt still counts as a RUN cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = Start_Addr;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (!Stall) begin
          cnt_en = 1'b1;
          if (Halt_req) begin
            state_d = HALTED;
          end else if (Branch_En) begin
            pc_d = Branch_Rel ? (pc_q + Target) : Target;
          end else begin
            pc_d = pc_q + W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALTED);
    end
  end

  sat_counter #(.WIDTH(CW)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (Reset_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (Cycle_Count)
  );

  assign PC      = pc_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule
